// File: rtl/cdm_pkg.sv
// Shared definitions for the CDM sequential approximate multiplier family.
//
// Contents:
//   cdm_state_e : transaction FSM states (IDLE, four sub-product states, OUT)
//   width_of()  : full operand width for a given half width (WIDTH = 2*HW)
//   rw_of()     : result width for a given half width (RW = 4*HW)
//   kw_of()     : width needed to carry a disregard column count 0..2*HW
//   ERR_CNT_W   : width of the saturating approximation-error counter
package cdm_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S_LL = 3'd1,
        S_HL = 3'd2,
        S_LH = 3'd3,
        S_HH = 3'd4,
        OUT  = 3'd5
    } cdm_state_e;

    localparam int ERR_CNT_W = 16;

    function automatic int width_of(input int hw);
        return 2 * hw;
    endfunction

    function automatic int rw_of(input int hw);
        return 4 * hw;
    endfunction

    function automatic int kw_of(input int hw);
        return $clog2(2 * hw + 1);
    endfunction

endpackage

// File: rtl/cdm_sub_mul.sv
// Combinational HW x HW carry-disregard sub-multiplier.
//
// The low k columns of the partial-product array are reduced to their parity
// and never produce a carry; columns k and above are summed exactly, with
// carries rippling only among themselves. k = 0 gives an exact product.
// The column count is a port rather than a parameter so a single instance can
// be time-shared between sub-products that use different counts.
//
// Ports:
//   x, y : HW-bit operands
//   k    : number of low columns whose carries are disregarded (0..2*HW)
//   p    : 2*HW-bit approximate product
module cdm_sub_mul
    import cdm_pkg::*;
#(
    parameter int HW = 8
) (
    input  logic [HW-1:0]          x,
    input  logic [HW-1:0]          y,
    input  logic [kw_of(HW)-1:0]   k,
    output logic [2*HW-1:0]        p
);

    localparam int PW = 2 * HW;

    logic [PW-1:0] mask_lo_s;
    logic [PW-1:0] row_s;
    logic [PW-1:0] hi_sum_s;
    logic [PW-1:0] par_s;

    // Split every partial-product row into an exact upper sum and a parity-only lower part
    always_comb begin
        mask_lo_s = '0;
        row_s     = '0;
        hi_sum_s  = '0;
        par_s     = '0;
        for (int c = 0; c < PW; c++) begin
            mask_lo_s[c] = (c < int'(k));
        end
        for (int i = 0; i < HW; i++) begin
            if (y[i]) begin
                row_s = PW'(x) << i;
            end else begin
                row_s = '0;
            end
            // Masked-off low bits are zero, so carries can only land at column k or above
            hi_sum_s = hi_sum_s + (row_s & ~mask_lo_s);
            par_s    = par_s ^ (row_s & mask_lo_s);
        end
    end

    // Upper and lower parts occupy disjoint columns
    assign p = hi_sum_s | par_s;

endmodule

// File: rtl/cdm_seq_mul.sv
// Sequential carry-disregard approximate multiplier (CDM family).
//
// Operands of WIDTH = 2*HW bits are split into halves; the four quadrant
// sub-products LL, HL, LH, HH are formed on one shared cdm_sub_mul over four
// cycles and merged into HW-bit result lanes. In approximate mode inter-lane
// carries are dropped and each sub-product disregards carries in its low
// columns; in exact mode r == a*b. approx_en is captured with the operands.
//
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  : operand handshake (a, b, approx_en)
//   out_valid, out_ready: result handshake (r)
//   r                   : 4*HW-bit product, held stable until the next result
//   err_cnt, err_flag   : only with CDM_ERR_STAT_EN defined; err_flag marks a
//                         result differing from the exact product, err_cnt
//                         counts such results (saturating) at OUT handshakes
//
// Optional feature macro: CDM_ERR_STAT_EN
module cdm_seq_mul
    import cdm_pkg::*;
#(
    parameter int HW      = 8,
    parameter int K_LL    = 8,
    parameter int K_CROSS = 4,
    parameter int K_HH    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*HW-1:0]      a,
    input  logic [2*HW-1:0]      b,
    input  logic                 approx_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*HW-1:0]      r
`ifdef CDM_ERR_STAT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 err_flag
`endif
);

    localparam int WIDTH = width_of(HW);
    localparam int RW    = rw_of(HW);
    localparam int KW    = kw_of(HW);
    localparam int PW    = 2 * HW;

    localparam logic [KW-1:0] K_LL_V    = KW'(K_LL);
    localparam logic [KW-1:0] K_CROSS_V = KW'(K_CROSS);
    localparam logic [KW-1:0] K_HH_V    = KW'(K_HH);

    cdm_state_e       state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             approx_r;
    logic [PW-1:0]    p_ll_r;
    logic [PW-1:0]    p_hl_r;
    logic [PW-1:0]    p_lh_r;

    logic [HW-1:0]    sub_x_s;
    logic [HW-1:0]    sub_y_s;
    logic [KW-1:0]    sub_k_s;
    logic [PW-1:0]    sub_p_s;

    logic [HW-1:0]    lane1_s;
    logic [HW-1:0]    lane2_s;
    logic [RW-1:0]    approx_asm_s;
    logic [RW-1:0]    exact_asm_s;
    logic [RW-1:0]    asm_s;

    // Route the quadrant operands and disregard count for the current state to the shared sub-multiplier
    always_comb begin
        sub_x_s = '0;
        sub_y_s = '0;
        sub_k_s = '0;
        case (state_r)
            S_LL: begin
                sub_x_s = a_r[HW-1:0];
                sub_y_s = b_r[HW-1:0];
                sub_k_s = approx_r ? K_LL_V : KW'(0);
            end
            S_HL: begin
                sub_x_s = a_r[WIDTH-1:HW];
                sub_y_s = b_r[HW-1:0];
                sub_k_s = approx_r ? K_CROSS_V : KW'(0);
            end
            S_LH: begin
                sub_x_s = a_r[HW-1:0];
                sub_y_s = b_r[WIDTH-1:HW];
                sub_k_s = approx_r ? K_CROSS_V : KW'(0);
            end
            S_HH: begin
                sub_x_s = a_r[WIDTH-1:HW];
                sub_y_s = b_r[WIDTH-1:HW];
                sub_k_s = approx_r ? K_HH_V : KW'(0);
            end
            default: begin
                sub_x_s = '0;
                sub_y_s = '0;
                sub_k_s = '0;
            end
        endcase
    end

    cdm_sub_mul #(
        .HW (HW)
    ) u_sub_mul (
        .x (sub_x_s),
        .y (sub_y_s),
        .k (sub_k_s),
        .p (sub_p_s)
    );

    // Merge sub-products into lanes; HH comes straight from the sub-multiplier since assembly happens in S_HH
    always_comb begin
        // HW-bit sums wrap naturally, which is exactly the dropped inter-lane carry
        lane1_s      = p_ll_r[PW-1:HW] + p_hl_r[HW-1:0] + p_lh_r[HW-1:0];
        lane2_s      = p_hl_r[PW-1:HW] + p_lh_r[PW-1:HW] + sub_p_s[HW-1:0];
        approx_asm_s = {sub_p_s[PW-1:HW], lane2_s, lane1_s, p_ll_r[HW-1:0]};
        exact_asm_s  = RW'(p_ll_r)
                     + (RW'(p_hl_r) << HW)
                     + (RW'(p_lh_r) << HW)
                     + (RW'(sub_p_s) << PW);
        if (approx_r) begin
            asm_s = approx_asm_s;
        end else begin
            asm_s = exact_asm_s;
        end
    end

    // Transaction FSM with registered handshake outputs and result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            approx_r  <= 1'b0;
            p_ll_r    <= '0;
            p_hl_r    <= '0;
            p_lh_r    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            r         <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        b_r      <= b;
                        approx_r <= approx_en;
                        in_ready <= 1'b0;
                        state_r  <= S_LL;
                    end
                end
                S_LL: begin
                    p_ll_r  <= sub_p_s;
                    state_r <= S_HL;
                end
                S_HL: begin
                    p_hl_r  <= sub_p_s;
                    state_r <= S_LH;
                end
                S_LH: begin
                    p_lh_r  <= sub_p_s;
                    state_r <= S_HH;
                end
                S_HH: begin
                    r         <= asm_s;
                    out_valid <= 1'b1;
                    state_r   <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

`ifdef CDM_ERR_STAT_EN
    logic [RW-1:0] exact_s;

    // Reference product computed from the latched operands
    always_comb begin
        exact_s = RW'(a_r) * RW'(b_r);
    end

    // Flag results that differ from the exact product and count them at the output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag <= 1'b0;
            err_cnt  <= '0;
        end else begin
            if (state_r == S_HH) begin
                err_flag <= (asm_s != exact_s);
            end
            if ((state_r == OUT) && out_ready && err_flag && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: doc/cdm_seq_mul.md
Name: cdm_seq_mul

Overview:
- Parametrised, sequential carry-disregard approximate multiplier for the CDM family.
- Splits WIDTH = 2*HW operands into halves and computes the four quadrant sub-products (LL, HL, LH, HH) over four cycles on one shared sub-multiplier.
- Merges results into HW-bit byte lanes; carries between lanes are disregarded in approximate mode.
- Sits behind a valid/ready stream interface. A runtime mode input selects approximate or exact operation per transaction.

Parameters:
- HW, 8: half-operand width; WIDTH = 2*HW; result width 4*HW.
- K_LL, 8: low columns of the LL sub-product whose carries are disregarded.
- K_CROSS, 4: disregarded low columns for the HL and LH sub-products.
- K_HH, 0: disregarded low columns for HH (0 = exact).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  2*HW  multiplicand.
- b  in  2*HW  multiplier.
- approx_en  in  1  1 = approximate, 0 = exact; sampled with operands.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- r  out  4*HW  product.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; out_valid=0; r=0; all operand and sub-product registers 0.
  - in_ready=1 once rst_n deasserts.
- FSM states: IDLE -> S_LL -> S_HL -> S_LH -> S_HH -> OUT -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch a, b, approx_en; go to S_LL.
- Sub-product states (one per cycle, no stalls):
  - S_LL: p_ll = sub(a_lo, b_lo, K_LL).
  - S_HL: p_hl = sub(a_hi, b_lo, K_CROSS).
  - S_LH: p_lh = sub(a_lo, b_hi, K_CROSS).
  - S_HH: p_hh = sub(a_hi, b_hi, K_HH).
  - After S_HH, go to OUT.
- Sub-product rule sub(x, y, K), 2*HW-bit result:
  - Partial-product rows are x&y[i] shifted by i.
  - Columns c >= K: exact sum of their bits. Carries from these columns propagate normally.
  - Columns c < K: bit c = XOR (parity) of the column's bits; no carry is generated out of the column.
  - Final result = exact upper part + parity lower bits.
  - When latched approx_en=0, K is forced to 0 for all four sub-products.
- Lane assembly, registered into r on the S_HH -> OUT edge:
  - lane0 = p_ll[HW-1:0].
  - lane1 = p_ll_hi + p_hl_lo + p_lh_lo.
  - lane2 = p_hl_hi + p_lh_hi + p_hh_lo.
  - lane3 = p_hh_hi.
  - approx_en=1: each lane sum is mod 2^HW; carries out of lane1 and lane2 are dropped.
  - approx_en=0: full carry propagation, so r == a*b exactly.
- OUT:
  - out_valid=1; r held stable.
  - in_ready=0.
  - Stays in OUT until out_ready=1, then goes to IDLE. out_valid falls the next cycle; r retains its value.
- Latency and throughput:
  - out_valid rises 5 edges after the accept edge (accept, LL, HL, LH, HH).
  - Minimum initiation interval 6 cycles.
- Boundary conditions:
  - in_valid while busy: ignored (in_ready=0); no operand change affects the current transaction.
  - approx_en changes mid-transaction: no effect.
  - out_ready held high: OUT lasts exactly 1 cycle.
  - rst_n asserted in any state: immediate IDLE and out_valid=0; the in-flight result is discarded.
  - Zero operand: r=0 in both modes.

Optional Feature:
- Macro: CDM_ERR_STAT_EN.
- Defined:
  - Adds output err_cnt (16 bits, saturating at 0xFFFF, reset 0) and output err_flag (1 bit, valid with out_valid).
  - An exact a*b is registered alongside the approximate result.
  - err_flag = (r != exact).
  - err_cnt increments on each OUT handshake with err_flag=1.
- Undefined: neither port nor the exact multiplier exists; behaviour otherwise identical.

Decomposition:
- Package cdm_pkg:
  - state enum (IDLE, S_LL, S_HL, S_LH, S_HH, OUT);
  - localparam helpers for WIDTH and RW (result width);
  - ERR_CNT_W = 16.
- Sub-module cdm_sub_mul:
  - parameters HW, K; combinational sub(x, y, K) per the rule above;
  - one instance, time-shared across the four sub-product states with muxed operands and K.

Test Plan:
- Exact mode: approx_en=0, a=0xFFFF, b=0xFFFF -> r=0xFFFE0001; out_valid 5 edges after accept.
- Lane carry dropped: approx_en=1, a=0xFFFF, b=0x0101 -> r=0x00FFFEFF. Same operands with approx_en=0 -> 0x0100FEFF.
- Column carry dropped in LL: approx_en=1, a=0x0003, b=0x0003 -> r=0x00000005. approx_en=0 -> 0x00000009.
- Backpressure: out_ready=0 for 10 cycles -> out_valid and r stable, in_ready=0. Second in_valid is ignored, then accepted after the handshake.
- Reset mid-operation: rst_n low during S_HL -> out_valid=0, r=0, in_ready=1 after release. A new a=0x0100, b=0x0100 then yields r=0x00010000.
- CDM_ERR_STAT_EN: run the two approximate vectors (0xFFFF×0x0101 and 0x0003×0x0003) then 0x0100×0x0100 -> err_flag 1, 1, 0; err_cnt=2.
